// File: rtl/evict_ds_serializer_if.sv
// Eviction data serializer: shared types and the chunk-in / beat-out interface.
// The interface carries the EVDB-side chunk channel and the downstream beat channel.
package evict_ds_pkg;
  localparam int CHUNK_W  = 1024;
  localparam int BUS_W    = 128;
  localparam int BEATS    = CHUNK_W / BUS_W;
  localparam int TAG_W    = 20;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 9;
  localparam int ROB_W    = 6;
  localparam int DB_W     = 4;
  localparam int TXNID_W  = 8;
  localparam int SB_W     = 8;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [ROB_W-1:0]    rob_entry_id;
    logic [DB_W-1:0]     db_entry_id;
    logic [TXNID_W-1:0]  txnid;
    logic [SB_W-1:0]     sideband;
    logic                last;
  } arb_out_req_t;

  typedef struct packed {
    logic [CHUNK_W-1:0] data;
    arb_out_req_t       evict_req_pld;
  } ram_to_evdb_pld_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } evict_addr_t;

  typedef struct packed {
    logic [BUS_W-1:0]   data;
    evict_addr_t        addr;
    logic               last;
    logic [ROB_W-1:0]   rob_entry_id;
    logic [DB_W-1:0]    db_entry_id;
    logic [TXNID_W-1:0] txnid;
    logic [SB_W-1:0]    sideband;
  } evict_to_ds_pld_t;
endpackage

interface evict_ds_serializer_if;
  import evict_ds_pkg::*;

  logic             in_vld;
  logic             in_rdy;
  ram_to_evdb_pld_t in_pld;
  logic             out_vld;
  logic             out_rdy;
  evict_to_ds_pld_t out_pld;

  modport master (
    output in_vld, in_pld, out_rdy,
    input  in_rdy, out_vld, out_pld
  );

  modport slave (
    input  in_vld, in_pld, out_rdy,
    output in_rdy, out_vld, out_pld
  );
endinterface

// File: rtl/evict_ds_serializer.sv
// Eviction data serializer: 2-entry chunk FIFO draining 1024-bit chunks
// as 128-bit beats with per-beat address and eviction-final last flag.
module evict_ds_serializer
  import evict_ds_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  evict_ds_serializer_if.slave     bus,
  output logic                     busy,
  output logic [$clog2(BEATS)-1:0] beat_idx
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int BIDX_W  = $clog2(BEATS);
  localparam int BYTE_SH = $clog2(BUS_W / 8);

  ram_to_evdb_pld_t   mem [FIFO_DEPTH];
  ram_to_evdb_pld_t   head;
  arb_out_req_t       req;
  evict_to_ds_pld_t   beat;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [BIDX_W-1:0]  beat_q;
  logic               push;
  logic               pop;
  logic               beat_hs;
  logic               last_beat;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // No full-bypass: in_rdy depends only on the stored count.
  assign bus.in_rdy  = count < CNT_W'(FIFO_DEPTH);
  assign bus.out_vld = count != '0;
  assign busy        = bus.out_vld;
  assign beat_idx    = beat_q;

  assign push      = bus.in_vld && bus.in_rdy;
  assign beat_hs   = bus.out_vld && bus.out_rdy;
  assign last_beat = beat_q == BIDX_W'(BEATS - 1);
  assign pop       = beat_hs && last_beat;

  assign head = mem[rd_ptr];
  assign req  = head.evict_req_pld;

  // Chunk storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_pld;
  end

  // Pointers, occupancy and beat position.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (beat_hs) beat_q <= last_beat ? '0 : beat_q + BIDX_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Beat slice and address for the head chunk; offset wraps in 512 B.
  always_comb begin
    beat              = '0;
    beat.data         = head.data[beat_q*BUS_W +: BUS_W];
    beat.addr.tag     = req.tag;
    beat.addr.index   = req.index;
    beat.addr.offset  = req.offset
                      + OFFSET_W'({beat_q, {BYTE_SH{1'b0}}});
    beat.last         = req.last && last_beat;
    beat.rob_entry_id = req.rob_entry_id;
    beat.db_entry_id  = req.db_entry_id;
    beat.txnid        = req.txnid;
    beat.sideband     = req.sideband;
  end

  assign bus.out_pld = beat;

endmodule

// File: tb/tb_evict_ds_serializer.sv
// Bench for evict_ds_serializer: directed scenarios plus random traffic
// against a queue-of-beats reference model.
module tb_evict_ds_serializer;
  import evict_ds_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [2:0] beat_idx;

  always #5 clk = ~clk;

  evict_ds_serializer_if bus();

  evict_ds_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .beat_idx (beat_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  evict_to_ds_pld_t exp_q[$];
  int n_chunks = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic evict_to_ds_pld_t mk_beat(
    input ram_to_evdb_pld_t c, input int k);
    evict_to_ds_pld_t b;
    logic [CHUNK_W-1:0] sh;
    int off;
    sh = c.data >> (k * BUS_W);
    off = (int'(c.evict_req_pld.offset) + k * (BUS_W / 8)) % 512;
    b.data         = sh[BUS_W-1:0];
    b.addr.tag     = c.evict_req_pld.tag;
    b.addr.index   = c.evict_req_pld.index;
    b.addr.offset  = OFFSET_W'(off);
    b.last         = c.evict_req_pld.last && (k == BEATS - 1);
    b.rob_entry_id = c.evict_req_pld.rob_entry_id;
    b.db_entry_id  = c.evict_req_pld.db_entry_id;
    b.txnid        = c.evict_req_pld.txnid;
    b.sideband     = c.evict_req_pld.sideband;
    return b;
  endfunction

  function automatic ram_to_evdb_pld_t rand_chunk();
    ram_to_evdb_pld_t c;
    for (int i = 0; i < CHUNK_W / 32; i++)
      c.data[i*32 +: 32] = $urandom();
    c.evict_req_pld.tag          = TAG_W'($urandom());
    c.evict_req_pld.index        = INDEX_W'($urandom());
    c.evict_req_pld.offset       = OFFSET_W'($urandom());
    c.evict_req_pld.rob_entry_id = ROB_W'($urandom());
    c.evict_req_pld.db_entry_id  = DB_W'($urandom());
    c.evict_req_pld.txnid        = TXNID_W'($urandom());
    c.evict_req_pld.sideband     = SB_W'($urandom());
    c.evict_req_pld.last         = 1'($urandom());
    return c;
  endfunction

  // One clock: drive, check at negedge, advance the model, return at posedge+1.
  task automatic step(input logic v, input ram_to_evdb_pld_t p,
                      input logic r, input logic rs,
                      output logic accepted);
    logic exp_vld;
    logic can_push;
    int   exp_idx;
    bus.in_vld  = v;
    bus.in_pld  = p;
    bus.out_rdy = r;
    rst         = rs;
    @(negedge clk);
    exp_vld  = exp_q.size() != 0;
    can_push = n_chunks < 2;
    exp_idx  = (BEATS - (exp_q.size() % BEATS)) % BEATS;
    chk("in_rdy", bus.in_rdy, can_push);
    chk("out_vld", bus.out_vld, exp_vld);
    chk("busy", busy, exp_vld);
    chk("beat_idx", beat_idx, exp_idx);
    if (exp_vld) chk("out_pld", bus.out_pld, exp_q[0]);
    accepted = 1'b0;
    if (rs) begin
      exp_q.delete();
      n_chunks = 0;
    end else begin
      if (exp_vld && r) begin
        void'(exp_q.pop_front());
        if (exp_q.size() % BEATS == 0) n_chunks--;
      end
      if (v && can_push) begin
        for (int k = 0; k < BEATS; k++) exp_q.push_back(mk_beat(p, k));
        n_chunks++;
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_chunk(input ram_to_evdb_pld_t c, input logic r);
    logic acc;
    int   guard;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 40) begin
      step(1'b1, c, r, 1'b0, acc);
      guard++;
    end
    if (!acc) chk("push_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input int max_cycles);
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step(1'b0, '0, 1'b1, 1'b0, acc);
      n++;
    end
    step(1'b0, '0, 1'b1, 1'b0, acc);
    if (exp_q.size() != 0) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    ram_to_evdb_pld_t c;
    ram_to_evdb_pld_t cs [3];
    logic acc;
    logic rr;
    rst         = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_pld  = '0;
    bus.out_rdy = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);

    // single chunk, beat k carries k
    c = rand_chunk();
    c.data = '0;
    for (int k = 0; k < BEATS; k++) c.data[k*BUS_W +: BUS_W] = BUS_W'(k);
    c.evict_req_pld.offset = '0;
    c.evict_req_pld.last   = 1'b1;
    push_chunk(c, 1'b1);
    drain(20);

    // backpressure pattern 1,0,0,1,...
    push_chunk(rand_chunk(), 1'b1);
    for (int i = 0; i < 40; i++) begin
      rr = (i % 3) == 0;
      step(1'b0, '0, rr, 1'b0, acc);
    end
    drain(20);

    // three chunks back to back
    for (int i = 0; i < 3; i++) cs[i] = rand_chunk();
    for (int i = 0; i < 3; i++) push_chunk(cs[i], 1'b1);
    drain(40);

    // offset wrap
    c = rand_chunk();
    c.evict_req_pld.offset = 9'h1C0;
    push_chunk(c, 1'b1);
    drain(20);

    // four-chunk eviction, last only at the end
    for (int i = 0; i < 4; i++) begin
      c = rand_chunk();
      c.evict_req_pld.rob_entry_id = 6'd17;
      c.evict_req_pld.txnid        = 8'hA5;
      c.evict_req_pld.last         = (i == 3);
      push_chunk(c, 1'b1);
    end
    drain(60);

    // reset mid-chunk with two entries buffered
    push_chunk(rand_chunk(), 1'b0);
    push_chunk(rand_chunk(), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b1, rand_chunk(), 1'b1, 1'b1, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    push_chunk(rand_chunk(), 1'b1);
    drain(20);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), rand_chunk(),
           1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 299) == 0, acc);
    end
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/evict_ds_serializer.md
Name: evict_ds_serializer

Overview:
- Sits directly downstream of the evict data buffer (EVDB).
- Accepts 1024-bit eviction chunks (ram_to_evdb_pld_t), each read out of the data SRAM group, and serializes every chunk into BUS_WIDTH-bit beats (evict_to_ds_pld_t) toward the downstream write channel.
- Holds a 2-entry chunk FIFO so the EVDB can hand over the next chunk while the current one drains.
- Generates the per-beat address and the eviction-final `last` flag.

Parameters:
- CHUNK_W, 1024, width of one input data chunk in bits.
- BUS_W, BUS_WIDTH (128), output beat width in bits.
- BEATS, CHUNK_W/BUS_W (8), beats per chunk.
- FIFO_DEPTH, 2, chunk buffer entries.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  chunk valid from EVDB.
- in_rdy  out  1  chunk accepted when in_vld&&in_rdy.
- in_pld  in  $bits(ram_to_evdb_pld_t)  data[1023:0] plus evict_req_pld (arb_out_req_t).
- out_vld  out  1  beat valid to downstream.
- out_rdy  in  1  downstream accepts beat.
- out_pld  out  $bits(evict_to_ds_pld_t)  beat data, addr, last, rob_entry_id, db_entry_id, txnid, sideband.
- busy  out  1  FIFO non-empty.
- beat_idx  out  $clog2(BEATS)  index of the beat currently presented.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO write/read pointers, count and beat counter cleared to 0.
  - Registered outputs are 0 from the next cycle: out_vld=0, busy=0, beat_idx=0, in_rdy=1.
  - Reset mid-chunk discards all buffered chunks and partial beats; no beat is emitted afterwards for discarded data.
- Input handshake:
  - in_rdy = (count < FIFO_DEPTH).
  - No full-bypass: a push while full is not allowed even if a pop happens in the same cycle.
  - Push writes in_pld at wr_ptr; wr_ptr wraps at FIFO_DEPTH.
- Output path:
  - out_vld = (count != 0).
  - out_pld is driven combinationally from the head entry and beat_idx.
  - out_pld must stay stable while out_vld && !out_rdy (AXI-style; head and beat_idx do not change without a handshake).
- Beat fields:
  - data = head.data[beat_idx*BUS_W +: BUS_W]; beat 0 is the LSBs.
  - addr.tag = head.evict_req_pld.tag.
  - addr.index = head.evict_req_pld.index.
  - addr.offset = head.offset + beat_idx*(BUS_W/8), truncated to OFFSET_WIDTH (wraps modulo 512 bytes).
  - rob_entry_id, db_entry_id, txnid, sideband are copied from head.evict_req_pld.
  - last = head.evict_req_pld.last && (beat_idx == BEATS-1).
- Beat counter:
  - On out handshake with beat_idx < BEATS-1: beat_idx increments.
  - On handshake with beat_idx == BEATS-1: beat_idx returns to 0, the head is popped, rd_ptr advances and wraps.
- Simultaneous push and pop (count=1, or count=2 with in_rdy=0, so no push): count is unchanged on push+pop; otherwise it is ±1.
- Latency: a chunk pushed into an empty FIFO at cycle N presents beat 0 at cycle N+1. At full throughput (out_rdy=1) one chunk takes 8 cycles.
- Back-to-back chunks:
  - With out_rdy held at 1, beat 7 of chunk A is followed in the very next cycle by beat 0 of chunk B, with no bubble.
  - in_rdy never throttles the EVDB below one chunk per 8 cycles.
- Chunk ordering is strict FIFO; beats are never reordered or interleaved across chunks.
- A chunk with evict_req_pld.last=0 produces last=0 on all 8 beats.
- busy = (count != 0), registered-equivalent: it follows count.

Test Plan:
- Reset then single chunk: data = {beat k = 128'hk repeated}, offset=0, last=1, out_rdy=1 → 8 beats with data k=0..7, addr.offset 0,16,…,112, last only on beat 7, busy deasserts the cycle after beat 7.
- Backpressure: out_rdy toggles 1,0,0,1… → out_pld stable across stall cycles; exactly 8 beats; no duplication or skipping.
- Three chunks pushed on consecutive cycles, out_rdy=1 → in_rdy drops after the 2nd push and rises the cycle after chunk 1's beat 7; 24 contiguous beats in order with no bubbles.
- Offset wrap: offset=9'h1C0 → beat offsets 0x1C0,0x1D0,0x1E0,0x1F0,0x000,0x010,0x020,0x030.
- Four-chunk eviction (last=0,0,0,1) with rob_entry_id=6'd17 and txnid propagated → 32 beats, last only on beat 31, rob_entry_id=17 on every beat.
- rst asserted during beat 3 of a chunk with 2 entries buffered → next cycle out_vld=0, in_rdy=1, beat_idx=0; a new chunk then starts cleanly at beat 0.
